// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for the datapath.
// Optional single-step mode is enabled with `define SINGLE_STEP_EN.
module control_sequencer #(
  parameter int INSTR_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [31:0]            ir,
  input  logic                   stop,
`ifdef SINGLE_STEP_EN
  input  logic                   step,
`endif
  output logic [15:0]            Rin,
  output logic [15:0]            Rout,
  output logic                   PCout,
  output logic                   PCin,
  output logic                   incPC,
  output logic                   MARin,
  output logic                   MDRin,
  output logic                   MDRout,
  output logic                   read,
  output logic                   IRin,
  output logic                   Yin,
  output logic                   Zin,
  output logic                   ZLowOut,
  output logic                   ZHighOut,
  output logic                   HIin,
  output logic                   LOin,
  output logic                   Cout,
  output logic [4:0]             opcode,
  output logic                   run,
  output logic [INSTR_CNT_W-1:0] instr_count
);

`ifdef SINGLE_STEP_EN
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6,
    S_HALTED, S_PAUSE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6,
    S_HALTED
  } state_t;
`endif

  localparam logic [4:0] OP_NOP = 5'b11010;

  state_t                 r_state;
  state_t                 w_next;
  logic [4:0]             r_opcode;
  logic [INSTR_CNT_W-1:0] r_count;
  logic [4:0]             w_op;
  logic [15:0]            w_ra_hot;
  logic [15:0]            w_rb_hot;
  logic [15:0]            w_rc_hot;
  logic                   w_alur;
  logic                   w_imm;
  logic                   w_muldiv;
  logic                   w_unary;
  logic                   w_halt;
  logic                   w_exec;
  logic                   w_retire;
  logic                   w_op_en;
  logic                   w_unused;
`ifdef SINGLE_STEP_EN
  logic                   r_step;
`endif

  assign w_op     = ir[31:27];
  assign w_ra_hot = 16'd1 << ir[26:23];
  assign w_rb_hot = 16'd1 << ir[22:19];
  assign w_rc_hot = 16'd1 << ir[18:15];
  assign w_unused = ^ir[14:0];

  assign w_alur   = (w_op <= 5'd11);
  assign w_imm    = (w_op >= 5'd12) && (w_op <= 5'd14);
  assign w_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_unary  = (w_op == 5'd17) || (w_op == 5'd18);
  assign w_halt   = (w_op == 5'b11011);
  assign w_exec   = w_alur | w_imm | w_muldiv | w_unary;

  assign run = (r_state != S_RST) && (r_state != S_HALTED);
  assign instr_count = r_count;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state  <= S_RST;
      r_opcode <= OP_NOP;
      r_count  <= '0;
    end else begin
      r_state  <= w_next;
      r_opcode <= opcode;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end

`ifdef SINGLE_STEP_EN
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_step <= 1'b0;
    else        r_step <= step;
  end
`endif

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_op_en  = 1'b0;
    Rin      = '0;
    Rout     = '0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    incPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    read     = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Cout     = 1'b0;
    unique case (r_state)
      S_RST: w_next = S_T0;
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        incPC  = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        read   = 1'b1;
        MDRin  = 1'b1;
        w_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        if (w_exec) w_next   = S_T3;
        else        w_retire = 1'b1;
      end
      S_T3: begin
        w_next = S_T4;
        unique case (1'b1)
          w_alur, w_imm: begin
            Rout = w_rb_hot;
            Yin  = 1'b1;
          end
          w_muldiv: begin
            Rout = w_ra_hot;
            Yin  = 1'b1;
          end
          w_unary: begin
            Rout    = w_rb_hot;
            w_op_en = 1'b1;
            Zin     = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        w_next = S_T5;
        unique case (1'b1)
          w_alur: begin
            Rout    = w_rc_hot;
            w_op_en = 1'b1;
            Zin     = 1'b1;
          end
          w_imm: begin
            Cout    = 1'b1;
            w_op_en = 1'b1;
            Zin     = 1'b1;
          end
          w_muldiv: begin
            Rout    = w_rb_hot;
            w_op_en = 1'b1;
            Zin     = 1'b1;
          end
          w_unary: begin
            ZLowOut  = 1'b1;
            Rin      = w_ra_hot;
            w_retire = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          w_alur, w_imm: begin
            ZLowOut  = 1'b1;
            Rin      = w_ra_hot;
            w_retire = 1'b1;
          end
          w_muldiv: begin
            ZLowOut = 1'b1;
            LOin    = 1'b1;
            w_next  = S_T6;
          end
          default: w_retire = 1'b1;
        endcase
      end
      S_T6: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
        w_retire = 1'b1;
      end
      S_HALTED: w_next = S_HALTED;
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (stop)                w_next = S_HALTED;
        else if (step && !r_step) w_next = S_T0;
      end
`endif
      default: w_next = S_RST;
    endcase
    // A HALT opcode only retires from T2, so gate it on that state.
    if (w_retire) begin
      if (stop || ((r_state == S_T2) && w_halt))
        w_next = S_HALTED;
      else
`ifdef SINGLE_STEP_EN
        w_next = S_PAUSE;
`else
        w_next = S_T0;
`endif
    end
    opcode = w_op_en ? w_op : r_opcode;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vector bench for control_sequencer.
// Built with INSTR_CNT_W=4 so the retired-count wrap is reachable.
module tb_control_sequencer;

  localparam logic [14:0] F_PCOUT = 15'h4000;
  localparam logic [14:0] F_INCPC = 15'h1000;
  localparam logic [14:0] F_MARIN = 15'h0800;
  localparam logic [14:0] F_MDRIN = 15'h0400;
  localparam logic [14:0] F_MDROUT = 15'h0200;
  localparam logic [14:0] F_READ = 15'h0100;
  localparam logic [14:0] F_IRIN = 15'h0080;
  localparam logic [14:0] F_YIN = 15'h0040;
  localparam logic [14:0] F_ZIN = 15'h0020;
  localparam logic [14:0] F_ZLO = 15'h0010;
  localparam logic [14:0] F_ZHI = 15'h0008;
  localparam logic [14:0] F_HIIN = 15'h0004;
  localparam logic [14:0] F_LOIN = 15'h0002;
  localparam logic [14:0] F_COUT = 15'h0001;
  localparam logic [14:0] F_T0 = F_PCOUT | F_INCPC | F_MARIN;
  localparam logic [14:0] F_T1 = F_READ | F_MDRIN;
  localparam logic [14:0] F_T2 = F_MDROUT | F_IRIN;

  localparam logic [31:0] I_SHR = 32'h4A19_8000;
  localparam logic [31:0] I_MUL = 32'h7B38_0000;
  localparam logic [31:0] I_IMM = 32'h6090_0000;
  localparam logic [31:0] I_UNA = 32'h8AC8_0000;
  localparam logic [31:0] I_ILL = 32'hF800_0000;
  localparam logic [31:0] I_NOP = 32'hD000_0000;
  localparam logic [31:0] I_HLT = 32'hD800_0000;

  typedef struct {
    logic [31:0] ir;
    logic        stop;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [14:0] strb;
    logic [4:0]  opc;
    logic        run;
    logic [3:0]  cnt;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = 32'h0;
  logic        stop = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin;
  logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout;
  logic [4:0]  opcode;
  logic        run;
  logic [3:0]  instr_count;
  logic [14:0] strb;

  int nchk = 0;
  int nerr = 0;
  logic mon_en = 1'b0;
  logic rin_seen = 1'b0;
  vec_t tv[$];

  control_sequencer #(.INSTR_CNT_W(4)) dut (
    .clock(clock), .clear(clear), .ir(ir), .stop(stop),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .read(read), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
    .HIin(HIin), .LOin(LOin), .Cout(Cout),
    .opcode(opcode), .run(run), .instr_count(instr_count)
  );

  assign strb = {PCout, PCin, incPC, MARin, MDRin, MDRout, read,
                 IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout};

  always #5 clock = ~clock;

  always @(Rin) if (mon_en && Rin != 16'h0) rin_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] rin,
                         input logic [15:0] rout, input logic [14:0] s,
                         input logic [4:0] opc, input logic rn,
                         input logic [3:0] cnt);
    chk({tag, ".Rin"}, 32'(Rin), 32'(rin));
    chk({tag, ".Rout"}, 32'(Rout), 32'(rout));
    chk({tag, ".strobes"}, 32'(strb), 32'(s));
    chk({tag, ".opcode"}, 32'(opcode), 32'(opc));
    chk({tag, ".run"}, 32'(run), 32'(rn));
    chk({tag, ".count"}, 32'(instr_count), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [31:0] i, input logic s,
                     input logic [15:0] ri, input logic [15:0] ro,
                     input logic [14:0] f, input logic [4:0] o,
                     input logic rn, input logic [3:0] c);
    tv.push_back('{i, s, ri, ro, f, o, rn, c});
  endtask

  initial begin
    // Row ir is the value present before the edge; T0 rows keep the
    // previous instruction since its retire decision reads ir.
    add(I_SHR, 0, 16'h0, 16'h0, F_T0, 5'h1A, 1, 0);
    add(I_SHR, 0, 16'h0, 16'h0, F_T1, 5'h1A, 1, 0);
    add(I_SHR, 0, 16'h0, 16'h0, F_T2, 5'h1A, 1, 0);
    add(I_SHR, 0, 16'h0, 16'h0008, F_YIN, 5'h1A, 1, 0);
    add(I_SHR, 0, 16'h0, 16'h0008, F_ZIN, 5'h09, 1, 0);
    add(I_SHR, 0, 16'h0010, 16'h0, F_ZLO, 5'h09, 1, 0);
    add(I_SHR, 0, 16'h0, 16'h0, F_T0, 5'h09, 1, 1);
    add(I_MUL, 0, 16'h0, 16'h0, F_T1, 5'h09, 1, 1);
    add(I_MUL, 0, 16'h0, 16'h0, F_T2, 5'h09, 1, 1);
    add(I_MUL, 0, 16'h0, 16'h0040, F_YIN, 5'h09, 1, 1);
    add(I_MUL, 0, 16'h0, 16'h0080, F_ZIN, 5'h0F, 1, 1);
    add(I_MUL, 0, 16'h0, 16'h0, F_ZLO | F_LOIN, 5'h0F, 1, 1);
    add(I_MUL, 0, 16'h0, 16'h0, F_ZHI | F_HIIN, 5'h0F, 1, 1);
    add(I_MUL, 0, 16'h0, 16'h0, F_T0, 5'h0F, 1, 2);
    add(I_IMM, 0, 16'h0, 16'h0, F_T1, 5'h0F, 1, 2);
    add(I_IMM, 0, 16'h0, 16'h0, F_T2, 5'h0F, 1, 2);
    add(I_IMM, 0, 16'h0, 16'h0004, F_YIN, 5'h0F, 1, 2);
    add(I_IMM, 1, 16'h0, 16'h0, F_COUT | F_ZIN, 5'h0C, 1, 2);
    add(I_IMM, 1, 16'h0002, 16'h0, F_ZLO, 5'h0C, 1, 2);
    add(I_IMM, 0, 16'h0, 16'h0, F_T0, 5'h0C, 1, 3);
    add(I_UNA, 0, 16'h0, 16'h0, F_T1, 5'h0C, 1, 3);
    add(I_UNA, 0, 16'h0, 16'h0, F_T2, 5'h0C, 1, 3);
    add(I_UNA, 0, 16'h0, 16'h0200, F_ZIN, 5'h11, 1, 3);
    add(I_UNA, 0, 16'h0020, 16'h0, F_ZLO, 5'h11, 1, 3);
    add(I_UNA, 0, 16'h0, 16'h0, F_T0, 5'h11, 1, 4);
    add(I_ILL, 0, 16'h0, 16'h0, F_T1, 5'h11, 1, 4);
    add(I_ILL, 0, 16'h0, 16'h0, F_T2, 5'h11, 1, 4);
    add(I_ILL, 0, 16'h0, 16'h0, F_T0, 5'h11, 1, 5);
    add(I_NOP, 0, 16'h0, 16'h0, F_T1, 5'h11, 1, 5);
    add(I_NOP, 1, 16'h0, 16'h0, F_T2, 5'h11, 1, 5);
    add(I_NOP, 1, 16'h0, 16'h0, 15'h0, 5'h11, 0, 6);

    #2 clear = 1'b0;
    #1 chk_all("reset_async", 16'h0, 16'h0, 15'h0, 5'h1A, 0, 0);
    repeat (3) tick();
    chk_all("reset_held", 16'h0, 16'h0, 15'h0, 5'h1A, 0, 0);
    clear = 1'b1;
    #2 chk_all("reset_rel", 16'h0, 16'h0, 15'h0, 5'h1A, 0, 0);

    foreach (tv[k]) begin
      ir = tv[k].ir;
      stop = tv[k].stop;
      tick();
      chk_all($sformatf("vec%0d", k), tv[k].rin, tv[k].rout,
              tv[k].strb, tv[k].opc, tv[k].run, tv[k].cnt);
    end

    stop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_all($sformatf("halted%0d", c), 16'h0, 16'h0, 15'h0, 5'h11,
              0, 6);
    end

    clear = 1'b0;
    tick();
    clear = 1'b1;
    ir = I_SHR;
    repeat (5) tick();
    chk("midop_T4.Rout", 32'(Rout), 32'h0008);
    chk("midop_T4.Zin", 32'(Zin), 32'h1);
    mon_en = 1'b1;
    #2 clear = 1'b0;
    #1 chk_all("midop_abort", 16'h0, 16'h0, 15'h0, 5'h1A, 0, 0);
    repeat (2) tick();
    clear = 1'b1;
    ir = I_NOP;
    tick();
    mon_en = 1'b0;
    chk("midop_no_rin", 32'(rin_seen), 32'h0);
    chk_all("wrap_T0", 16'h0, 16'h0, F_T0, 5'h1A, 1, 0);

    for (int n = 1; n <= 17; n++) begin
      repeat (3) tick();
      if (n >= 15)
        chk_all($sformatf("wrap_n%0d", n), 16'h0, 16'h0, F_T0,
                5'h1A, 1, 4'(n));
    end

    ir = I_HLT;
    tick();
    chk_all("halt_T1", 16'h0, 16'h0, F_T1, 5'h1A, 1, 1);
    tick();
    chk_all("halt_T2", 16'h0, 16'h0, F_T2, 5'h1A, 1, 1);
    tick();
    chk_all("halt_done", 16'h0, 16'h0, 15'h0, 5'h1A, 0, 2);
    repeat (3) tick();
    chk_all("halt_stay", 16'h0, 16'h0, 15'h0, 5'h1A, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
